// File: rtl/disp_select.sv
// Best/second-best disparity selector: scores each windowed candidate, drops low-texture windows,
// and reports the winning place with ambiguity, no-match and overflow flags at the end of a search.
module disp_select #(
  parameter int TEX_MIN     = 16,
  parameter int UNIQ_MARGIN = 8,
  parameter int MAX_CAND    = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic        in_last,
  input  logic [13:0] g2sum,
  input  logic [10:0] gsum,
  input  logic [13:0] fg,
  input  logic [5:0]  place,
  output logic        busy,
  output logic        res_valid,
  output logic [5:0]  best_place,
  output logic [15:0] best_score,
  output logic        ambiguous,
  output logic        no_match,
  output logic [6:0]  cand_count,
  output logic        overflow
);

  typedef enum logic [1:0] {IDLE, SEARCH, FLUSH, DONE} state_t;

  localparam logic [10:0]        TEX_MIN_W  = 11'(TEX_MIN);
  localparam logic [6:0]         MAX_CAND_W = 7'(MAX_CAND);
  localparam logic signed [16:0] MARGIN_W   = 17'(UNIQ_MARGIN);

  state_t             state_q, state_d;
  logic [6:0]         cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               s1_valid_q, s1_valid_d;
  logic               s1_elig_q, s1_elig_d;
  logic signed [15:0] s1_score_q, s1_score_d;
  logic [5:0]         s1_place_q, s1_place_d;
  logic               top_valid_q, top_valid_d;
  logic signed [15:0] top_score_q, top_score_d;
  logic [5:0]         top_place_q, top_place_d;
  logic               sec_valid_q, sec_valid_d;
  logic signed [15:0] sec_score_q, sec_score_d;
  logic               busy_q, busy_d;
  logic               res_valid_q, res_valid_d;
  logic [5:0]         out_place_q, out_place_d;
  logic [15:0]        out_score_q, out_score_d;
  logic               amb_q, amb_d;
  logic               no_match_q, no_match_d;
  logic [6:0]         out_count_q, out_count_d;
  logic               out_ovf_q, out_ovf_d;

  logic               active, take, accept;
  logic [6:0]         base_count;
  logic signed [15:0] score_new;
  logic signed [16:0] gap;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    s1_valid_d  = 1'b0;
    s1_elig_d   = s1_elig_q;
    s1_score_d  = s1_score_q;
    s1_place_d  = s1_place_q;
    top_valid_d = top_valid_q;
    top_score_d = top_score_q;
    top_place_d = top_place_q;
    sec_valid_d = sec_valid_q;
    sec_score_d = sec_score_q;
    res_valid_d = 1'b0;
    out_place_d = out_place_q;
    out_score_d = out_score_q;
    amb_d       = amb_q;
    no_match_d  = no_match_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    // A start pulse clears first, so a candidate in the same cycle joins the new search.
    active     = start || (state_q == SEARCH);
    base_count = start ? 7'd0 : cnt_q;
    take       = active && in_valid;
    accept     = take && (base_count < MAX_CAND_W);
    score_new  = $signed({1'b0, fg, 1'b0}) - $signed({2'b00, g2sum});
    gap        = {top_score_q[15], top_score_q} - {sec_score_q[15], sec_score_q};

    case (state_q)
      IDLE:    if (start) state_d = SEARCH;
      SEARCH:  state_d = SEARCH;
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (start) state_d = SEARCH;
    if (take && in_last) state_d = FLUSH;

    cnt_d = base_count + {6'd0, accept};
    ovf_d = (start ? 1'b0 : ovf_q) | (take && !accept);

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_elig_d  = (gsum >= TEX_MIN_W);
      s1_score_d = score_new;
      s1_place_d = place;
    end

    // Strict greater-than keeps the earlier candidate on ties.
    if (start) begin
      top_valid_d = 1'b0;
      top_score_d = '0;
      top_place_d = '0;
      sec_valid_d = 1'b0;
      sec_score_d = '0;
    end else if (s1_valid_q && s1_elig_q) begin
      if (!top_valid_q) begin
        top_valid_d = 1'b1;
        top_score_d = s1_score_q;
        top_place_d = s1_place_q;
      end else if (s1_score_q > top_score_q) begin
        sec_valid_d = 1'b1;
        sec_score_d = top_score_q;
        top_score_d = s1_score_q;
        top_place_d = s1_place_q;
      end else if (!sec_valid_q || (s1_score_q > sec_score_q)) begin
        sec_valid_d = 1'b1;
        sec_score_d = s1_score_q;
      end
    end

    // Results are published from DONE even if a new search starts in that same cycle.
    if (state_q == DONE) begin
      res_valid_d = 1'b1;
      out_place_d = top_valid_q ? top_place_q : 6'd0;
      out_score_d = top_valid_q ? top_score_q : 16'd0;
      amb_d       = top_valid_q && sec_valid_q && (gap < MARGIN_W);
      no_match_d  = !top_valid_q;
      out_count_d = cnt_q;
      out_ovf_d   = ovf_q;
    end else if (start) begin
      out_place_d = '0;
      out_score_d = '0;
      amb_d       = 1'b0;
      no_match_d  = 1'b0;
      out_count_d = '0;
      out_ovf_d   = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_elig_q   <= 1'b0;
      s1_score_q  <= '0;
      s1_place_q  <= '0;
      top_valid_q <= 1'b0;
      top_score_q <= '0;
      top_place_q <= '0;
      sec_valid_q <= 1'b0;
      sec_score_q <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      out_place_q <= '0;
      out_score_q <= '0;
      amb_q       <= 1'b0;
      no_match_q  <= 1'b0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      s1_valid_q  <= s1_valid_d;
      s1_elig_q   <= s1_elig_d;
      s1_score_q  <= s1_score_d;
      s1_place_q  <= s1_place_d;
      top_valid_q <= top_valid_d;
      top_score_q <= top_score_d;
      top_place_q <= top_place_d;
      sec_valid_q <= sec_valid_d;
      sec_score_q <= sec_score_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      out_place_q <= out_place_d;
      out_score_q <= out_score_d;
      amb_q       <= amb_d;
      no_match_q  <= no_match_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign busy       = busy_q;
  assign res_valid  = res_valid_q;
  assign best_place = out_place_q;
  assign best_score = out_score_q;
  assign ambiguous  = amb_q;
  assign no_match   = no_match_q;
  assign cand_count = out_count_q;
  assign overflow   = out_ovf_q;

endmodule

// File: tb/tb_disp_select.sv
// Randomized and directed bench for disp_select, checked against a list-based model that
// ranks the accepted candidates of each search directly from the scoring rules.
module tb_disp_select;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        in_last;
  logic [13:0] g2sum;
  logic [10:0] gsum;
  logic [13:0] fg;
  logic [5:0]  place;
  logic        busy;
  logic        res_valid;
  logic [5:0]  best_place;
  logic [15:0] best_score;
  logic        ambiguous;
  logic        no_match;
  logic [6:0]  cand_count;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  int qg2[$];
  int qgs[$];
  int qfg[$];
  int qpl[$];

  int gotPlace, gotScore, gotAmb, gotNone, gotCount, gotOvf;

  disp_select dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_last(in_last),
    .g2sum(g2sum), .gsum(gsum), .fg(fg), .place(place),
    .busy(busy), .res_valid(res_valid), .best_place(best_place), .best_score(best_score),
    .ambiguous(ambiguous), .no_match(no_match), .cand_count(cand_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clearQueue();
    qg2.delete(); qgs.delete(); qfg.delete(); qpl.delete();
  endtask

  task automatic pushCand(input int a, input int b, input int c, input int d);
    qg2.push_back(a); qgs.push_back(b); qfg.push_back(c); qpl.push_back(d);
  endtask

  task automatic addRandom(input int n, input int gsMin, input int gsMax);
    for (int i = 0; i < n; i++)
      pushCand($urandom_range(0, 16383), $urandom_range(gsMin, gsMax),
               $urandom_range(0, 16383), $urandom_range(0, 63));
  endtask

  task automatic driveCand(input int i, input bit last);
    in_valid = 1'b1;
    g2sum    = 14'(qg2[i]);
    gsum     = 11'(qgs[i]);
    fg       = 14'(qfg[i]);
    place    = 6'(qpl[i]);
    in_last  = last;
  endtask

  task automatic idleInputs();
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Reference: rank accepted, eligible candidates by score; earliest wins ties.
  task automatic modelExpect(output int ePlace, output int eScore, output int eAmb,
                             output int eNone, output int eCount, output int eOvf);
    int n, bestIdx, bestSc, secSc, sc;
    bit hasSec;
    n       = qg2.size();
    eCount  = (n > 64) ? 64 : n;
    eOvf    = (n > 64) ? 1 : 0;
    bestIdx = -1; bestSc = 0; secSc = 0; hasSec = 0;
    for (int i = 0; i < eCount; i++) begin
      sc = 2 * qfg[i] - qg2[i];
      if (qgs[i] >= 16 && (bestIdx < 0 || sc > bestSc)) begin
        bestIdx = i; bestSc = sc;
      end
    end
    for (int i = 0; i < eCount; i++) begin
      sc = 2 * qfg[i] - qg2[i];
      if (qgs[i] >= 16 && i != bestIdx && (!hasSec || sc > secSc)) begin
        hasSec = 1; secSc = sc;
      end
    end
    eNone  = (bestIdx < 0) ? 1 : 0;
    ePlace = (bestIdx < 0) ? 0 : qpl[bestIdx];
    eScore = (bestIdx < 0) ? 0 : bestSc;
    eAmb   = (hasSec && (bestSc - secSc) < 8) ? 1 : 0;
  endtask

  task automatic applyStimulus(input string name, input bit abortFirst, input bit startWithFirst);
    int n, pulses, latency;
    int ePlace, eScore, eAmb, eNone, eCount, eOvf;
    n = qg2.size();
    if (abortFirst) begin
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int j = 0; j < 2; j++) begin
        in_valid = 1'b1; in_last = 1'b0;
        g2sum = 14'($urandom_range(0, 100)); gsum = 11'd40;
        fg = 14'($urandom_range(5000, 16383)); place = 6'($urandom_range(0, 63));
        @(negedge clk);
      end
      in_valid = 1'b0;
    end else begin
      @(negedge clk);
    end
    if (!startWithFirst) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      start = startWithFirst && (i == 0);
      driveCand(i, i == n - 1);
      @(negedge clk);
    end
    idleInputs();
    checkOutput({name, "_busy"}, busy, 1);
    pulses = 0; latency = 0;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) @(negedge clk);
      if (res_valid) begin
        pulses++;
        if (latency == 0) begin
          latency  = k;
          gotPlace = best_place;
          gotScore = int'($signed(best_score));
          gotAmb   = ambiguous;
          gotNone  = no_match;
          gotCount = cand_count;
          gotOvf   = overflow;
        end
      end
    end
    modelExpect(ePlace, eScore, eAmb, eNone, eCount, eOvf);
    checkOutput({name, "_latency"}, latency, 3);
    checkOutput({name, "_pulses"}, pulses, 1);
    checkOutput({name, "_place"}, gotPlace, ePlace);
    checkOutput({name, "_score"}, gotScore, eScore);
    checkOutput({name, "_ambiguous"}, gotAmb, eAmb);
    checkOutput({name, "_no_match"}, gotNone, eNone);
    checkOutput({name, "_count"}, gotCount, eCount);
    checkOutput({name, "_overflow"}, gotOvf, eOvf);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_busy"}, busy, 0);
    checkOutput({name, "_res_valid"}, res_valid, 0);
    checkOutput({name, "_place"}, best_place, 0);
    checkOutput({name, "_score"}, best_score, 0);
    checkOutput({name, "_ambiguous"}, ambiguous, 0);
    checkOutput({name, "_no_match"}, no_match, 0);
    checkOutput({name, "_count"}, cand_count, 0);
    checkOutput({name, "_overflow"}, overflow, 0);
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0;
    idleInputs();
    g2sum = '0; gsum = '0; fg = '0; place = '0;
    #12;
    checkAllZero("reset");
    @(negedge clk); rst_n = 1'b1;

    clearQueue();
    pushCand(100, 50, 80, 0); pushCand(200, 60, 150, 16);
    pushCand(50, 60, 40, 32); pushCand(300, 60, 210, 48);
    applyStimulus("basic", 0, 0);
    checkOutput("basic_const_place", gotPlace, 48);
    checkOutput("basic_const_score", gotScore, 120);

    qfg[3] = 154;
    applyStimulus("lowlast", 0, 0);
    checkOutput("lowlast_const_place", gotPlace, 16);

    qfg[3] = 210; qfg[1] = 146;
    applyStimulus("gap28", 0, 0);

    clearQueue();
    pushCand(0, 20, 50, 8); pushCand(5, 20, 50, 24);
    applyStimulus("amb", 0, 0);
    checkOutput("amb_const_flag", gotAmb, 1);

    clearQueue();
    pushCand(0, 20, 50, 8); pushCand(0, 20, 50, 24);
    applyStimulus("tie", 0, 0);
    checkOutput("tie_const_place", gotPlace, 8);

    clearQueue();
    for (int i = 0; i < 5; i++)
      pushCand($urandom_range(0, 16383), 10, $urandom_range(0, 16383), $urandom_range(1, 63));
    applyStimulus("nomatch", 0, 0);
    checkOutput("nomatch_const_flag", gotNone, 1);

    clearQueue();
    pushCand(0, 30, 500, 5);
    applyStimulus("single", 0, 1);

    for (int t = 0; t < 6; t++) begin
      clearQueue();
      addRandom($urandom_range(1, 12), 5, 40);
      applyStimulus($sformatf("rand%0d", t), 0, t[0]);
    end

    clearQueue();
    addRandom(71, 0, 40);
    applyStimulus("overflow", 0, 0);
    checkOutput("overflow_const_count", gotCount, 64);
    checkOutput("overflow_const_flag", gotOvf, 1);

    clearQueue();
    pushCand(0, 20, 5, 4);
    applyStimulus("abort", 1, 0);
    checkOutput("abort_const_score", gotScore, 10);

    // Reset asserted while the search is in its flush cycle.
    clearQueue();
    pushCand(10, 30, 400, 9); pushCand(20, 30, 300, 19); pushCand(30, 30, 200, 29);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      driveCand(i, i == 2);
      @(negedge clk);
    end
    idleInputs();
    rst_n = 1'b0;
    #1;
    checkAllZero("rstflush");
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 2) rst_n = 1'b1;
      if (res_valid) pulses++;
    end
    checkOutput("rstflush_pulses", pulses, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/disp_select.md
Name: disp_select

Overview:
- Downstream of the window accumulator stage, which emits one candidate per `valid` strobe: g2sum, gsum, fg and candidate place.
- disp_select scores each candidate, rejects low-texture windows and tracks the best and second-best scores over one search.
- At the end of the search it emits the winning place (disparity) with ambiguity and no-match flags for the depth output stage.

Parameters:
- TEX_MIN, 16: minimum gsum for a candidate to be eligible.
- UNIQ_MARGIN, 8: minimum best-minus-second score gap for an unambiguous result.
- MAX_CAND, 64: maximum candidates per search; further candidates are ignored.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse: clear search state and begin a new search.
- in_valid  in  1  candidate strobe, one candidate per cycle when high.
- in_last  in  1  qualifies in_valid: this is the final candidate of the search.
- g2sum  in  14  sum of g squared.
- gsum  in  11  sum of g.
- fg  in  14  sum of f*g.
- place  in  6  candidate position.
- busy  out  1  high from start until res_valid.
- res_valid  out  1  one-cycle result pulse.
- best_place  out  6  place of the best eligible candidate.
- best_score  out  16  signed score of the best candidate.
- ambiguous  out  1  best-to-second gap is below UNIQ_MARGIN.
- no_match  out  1  no eligible candidate was seen.
- cand_count  out  7  candidates accepted in this search.
- overflow  out  1  a candidate arrived after MAX_CAND were already accepted.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; every output and internal register = 0.
- Reset applied mid-search aborts the search; no res_valid is produced.
- Score (stage 1, registered):
  - score = 2*fg - g2sum, signed 16-bit; zero-extend the inputs, no saturation needed (range is -16383..32766).
  - eligible = (gsum >= TEX_MIN).
- State machine:
  - IDLE: on start go to SEARCH, clear best/second/count/flags. in_valid is ignored in IDLE.
  - SEARCH: each accepted in_valid feeds stage 1.
    - Accepted means cand_count < MAX_CAND; cand_count then increments.
    - If cand_count == MAX_CAND, the candidate is dropped and overflow is set sticky.
    - A dropped candidate that carries in_last still ends the search.
    - in_valid with in_last goes to FLUSH.
  - FLUSH (one cycle): stage 2 consumes the final stage-1 result. Go to DONE.
  - DONE (one cycle): res_valid = 1; outputs hold from here until the next start. Go to IDLE.
- Stage 2 (compare), one cycle after stage 1, eligible candidates only:
  - If no best yet: best = cand.
  - Else if score > best_score: second = best, best = cand.
  - Else if no second yet, or score > second_score: second = cand.
  - Ties keep the earlier candidate (strict greater-than).
  - Ineligible candidates still count in cand_count.
- Latency: res_valid is asserted exactly 3 cycles after the clock edge sampling in_valid & in_last (stage 1, stage 2, DONE).
- Result flags:
  - no_match = 1 when no eligible candidate was seen; best_place = 0 and best_score = 0 in that case.
  - ambiguous = 1 when a second candidate exists and (best_score - second_score) < UNIQ_MARGIN.
  - ambiguous = 0 with exactly one eligible candidate.
- start with in_valid in the same cycle: the clear happens first, and that candidate is accepted as the first of the new search.
- start during SEARCH or FLUSH: abort the current search, no res_valid, restart cleanly. Candidates still in stage 1/2 are discarded.
- start in the DONE cycle: res_valid still pulses, then the new search begins.
- busy = 1 in SEARCH, FLUSH and DONE.

Test Plan:
- Four candidates (g2sum,gsum,fg,place), TEX_MIN=16, UNIQ_MARGIN=8:
  - (100,50,80,0), (200,60,150,16), (50,60,40,32), (300,60,210,48); the last carries in_last.
  - Required: best_place=48, best_score=120, ambiguous=0, no_match=0, cand_count=4, res_valid 3 cycles after the last candidate.
- Same sequence but the last candidate's fg=154 (score 8):
  - Required: best_place=16, best_score=100, second 60 (gap 40), ambiguous=0.
  - Then change the second candidate to (200,60,146,16), score 92: the 120-vs-92 gap is 28, ambiguous=0.
- Ambiguity and ties:
  - Scores 100 (place 8) and 95 (place 24) -> ambiguous=1, best_place=8.
  - Equal scores 100/100 at places 8 and 24 -> best_place=8, ambiguous=1.
- All candidates with gsum=10 -> no_match=1, best_place=0, cand_count=candidates sent.
- 70 candidates without in_last, then one with in_last:
  - Required: cand_count=64, overflow=1, a single res_valid pulse.
- Abort and reset:
  - start mid-search (after 2 candidates), then 1 candidate (0,20,5,4) with in_last -> res_valid once, best_place=4, best_score=10, cand_count=1.
  - rst_n low in FLUSH -> all outputs 0, no res_valid.
